mul_div_sequencer: RTL and testbench

//  Multi-cycle sequencer for the ALU's MULTIPLY (ALU_control=4'b1101) and DIVIDE (4'b1011) ops.

---
 rtl/mul_div_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_mul_div_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_sequencer.sv
// rtl/mul_div_sequencer.sv - iterative radix-2 multiply/divide sequencer with HI/LO results
//
// Purpose
//   Runs MULTIPLY (alu_control 4'b1101, shift-add) and DIVIDE (4'b1011, restoring)
//   one bit per cycle beside the single-cycle ALU. Holds busy while running so the
//   core stalls; results land in HI/LO on entry to DONE and stay stable between ops.
//
// Configuration
//   MD_SIGNED_EN  defined: two's complement operands; the engine works on magnitudes
//                 and the signs are applied as the result is written to HI/LO.
//                 undefined: unsigned multu/divu semantics.
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        synchronous, active-high
//   i_start        request, sampled only in IDLE
//   i_alu_control  op code (1101 mult, 1011 div, others ignored)
//   i_src_a        multiplicand / dividend
//   i_src_b        multiplier / divisor
//   i_abort        cancels an op in RUN
//   o_busy         high in RUN and DONE
//   o_done         one-cycle pulse in DONE; HI/LO valid
//   o_div_by_zero  set by a divide with divisor 0, cleared by the next accepted start
//   o_hi           mult: upper product, div: remainder
//   o_lo           mult: lower product, div: quotient

module mul_div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [3:0]       i_alu_control,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam logic [3:0] OP_MULT = 4'b1101;
  localparam logic [3:0] OP_DIV  = 4'b1011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  // mult: {partial product, remaining multiplier}; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] r_acc;
  // multiplicand for mult, divisor for div
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dbz;
`ifdef MD_SIGNED_EN
  logic               r_neg_lo;  // product sign (mult) or quotient sign (div)
  logic               r_neg_hi;  // remainder sign (div only)
`endif

  logic               w_is_mult_op;
  logic               w_is_div_op;
  logic               w_accept;
  logic               w_dbz_req;
  logic               w_last;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_rem_ge;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_is_mult_op = (i_alu_control == OP_MULT);
  assign w_is_div_op  = (i_alu_control == OP_DIV);
  assign w_accept     = i_start && (w_is_mult_op || w_is_div_op);
  assign w_dbz_req    = i_start && w_is_div_op && (i_src_b == '0);
  assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MD_SIGNED_EN
  assign w_mag_a = i_src_a[WIDTH-1] ? -i_src_a : i_src_a;
  assign w_mag_b = i_src_b[WIDTH-1] ? -i_src_b : i_src_b;
`else
  assign w_mag_a = i_src_a;
  assign w_mag_b = i_src_b;
`endif

  // Multiply step: conditionally add multiplicand into the upper half, keeping the
  // carry, then shift the whole accumulator right by one.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

  // Divide step: the shifted remainder can be WIDTH+1 bits; after a successful
  // subtract it is always below the divisor, so WIDTH bits hold the difference.
  assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_rem_ge  = (w_rem_sh >= {1'b0, r_opnd});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_opnd;

  always_comb begin
    w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
    if (r_is_div) begin
      if (w_rem_ge) w_acc_nxt = {w_rem_sub, r_acc[WIDTH-2:0], 1'b1};
      else          w_acc_nxt = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    w_res_hi = w_acc_nxt[2*WIDTH-1:WIDTH];
    w_res_lo = w_acc_nxt[WIDTH-1:0];
`ifdef MD_SIGNED_EN
    if (r_is_div) begin
      if (r_neg_hi) w_res_hi = -w_acc_nxt[2*WIDTH-1:WIDTH];
      if (r_neg_lo) w_res_lo = -w_acc_nxt[WIDTH-1:0];
    end else if (r_neg_lo) begin
      {w_res_hi, w_res_lo} = -w_acc_nxt;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dbz_req)     w_state_nxt = S_DONE;
        else if (w_accept) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (i_abort)     w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
`ifdef MD_SIGNED_EN
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= w_is_div_op;
            r_dbz    <= w_dbz_req;
            r_acc    <= {{WIDTH{1'b0}}, (w_is_div_op ? w_mag_a : w_mag_b)};
            r_opnd   <= w_is_div_op ? w_mag_b : w_mag_a;
`ifdef MD_SIGNED_EN
            r_neg_lo <= i_src_a[WIDTH-1] ^ i_src_b[WIDTH-1];
            r_neg_hi <= w_is_div_op & i_src_a[WIDTH-1];
`endif
            // Divide by zero skips RUN; the result is fixed, not computed.
            if (w_dbz_req) begin
              r_hi <= i_src_a;
              r_lo <= '1;
            end
          end
        end
        S_RUN: begin
          if (!i_abort) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb/tb_mul_div_sequencer.sv - self-checking scoreboard bench for mul_div_sequencer

module tb_mul_div_sequencer;

  localparam int W = 32;
  localparam logic [3:0] OP_MULT = 4'b1101;
  localparam logic [3:0] OP_DIV  = 4'b1011;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   alu_control;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         abort;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int   n_checks = 0;
  int   n_errors = 0;
  res_t sb_q[$];
  res_t exp_r;
  int   n_busy;
  int   done_at;

  mul_div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start),
    .i_alu_control (alu_control),
    .i_src_a       (src_a),
    .i_src_b       (src_b),
    .i_abort       (abort),
    .o_busy        (busy),
    .o_done        (done),
    .o_div_by_zero (div_by_zero),
    .o_hi          (hi),
    .o_lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t        r;
    logic [63:0] p;
    r.dbz = 1'b0;
    if (is_div && b == '0) begin
      r.hi  = a;
      r.lo  = '1;
      r.dbz = 1'b1;
    end else if (!is_div) begin
`ifdef MD_SIGNED_EN
      p = longint'($signed(a)) * longint'($signed(b));
`else
      p = {32'b0, a} * {32'b0, b};
`endif
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else begin
`ifdef MD_SIGNED_EN
      r.lo = W'($signed(a) / $signed(b));
      r.hi = W'($signed(a) % $signed(b));
`else
      r.lo = a / b;
      r.hi = a % b;
`endif
    end
    return r;
  endfunction

  // Scoreboard side: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_r = sb_q.pop_front();
        check("hi", hi, exp_r.hi);
        check("lo", lo, exp_r.lo);
        check("div_by_zero", div_by_zero, exp_r.dbz);
      end
    end
  end

  // Called at a negedge; drives start for one edge and counts busy cycles until idle.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int nb, output int da);
    start = 1'b1; alu_control = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0;
    da = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (done) da = nb;
    end
  endtask

  task automatic push(input logic [W-1:0] h, input logic [W-1:0] l, input logic d);
    res_t r;
    r.hi = h; r.lo = l; r.dbz = d;
    sb_q.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    bit           rdiv;

    reset = 1'b1; start = 1'b0; alu_control = 4'b0; src_a = '0; src_b = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);

    push(32'd0, 32'd42, 1'b0);
    run_op(OP_MULT, 32'd7, 32'd6, n_busy, done_at);
    check("mult_busy_cycles", n_busy, 33);
    check("mult_done_cycle", done_at, 33);

`ifdef MD_SIGNED_EN
    push(32'h0, 32'h1, 1'b0);
`else
    push(32'hFFFFFFFE, 32'h00000001, 1'b0);
`endif
    run_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, n_busy, done_at);

    push(32'd2, 32'd14, 1'b0);
    run_op(OP_DIV, 32'd100, 32'd7, n_busy, done_at);
    check("div_busy_cycles", n_busy, 33);

`ifdef MD_SIGNED_EN
    push(32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);
    run_op(OP_DIV, -32'sd100, 32'd7, n_busy, done_at);
`endif

    push(32'd5, 32'hFFFFFFFF, 1'b1);
    run_op(OP_DIV, 32'd5, 32'd0, n_busy, done_at);
    check("dbz_busy_cycles", n_busy, 1);
    check("dbz_done_cycle", done_at, 1);
    check("dbz_held_idle", div_by_zero, 1);
    push(32'd0, 32'd6, 1'b0);
    run_op(OP_MULT, 32'd2, 32'd3, n_busy, done_at);
    check("b2b_busy_cycles", n_busy, 33);

    // Unknown op code: no effect.
    start = 1'b1; alu_control = 4'b0000; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("bad_op_busy", busy, 0);
    check("bad_op_lo_kept", lo, 6);

    // Start during RUN is dropped.
    push(32'd0, 32'd42, 1'b0);
    start = 1'b1; alu_control = OP_MULT; src_a = 32'd7; src_b = 32'd6;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; alu_control = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    @(negedge clk);
    repeat (40) @(negedge clk);
    check("midrun_start_idle", busy, 0);

    for (int i = 0; i < 8; i++) begin
      ra   = $urandom;
      rb   = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 20));
      rdiv = (i % 2) == 1;
`ifdef MD_SIGNED_EN
      if (rdiv && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
`endif
      sb_q.push_back(model(rdiv, ra, rb));
      run_op(rdiv ? OP_DIV : OP_MULT, ra, rb, n_busy, done_at);
      check("rand_done_seen", (done_at > 0), 1);
    end
    exp_r = model(1'b1, ra, rb);

    // Abort at RUN cycle 10 keeps HI/LO and emits no done.
    start = 1'b1; alu_control = OP_MULT; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi_kept", hi, exp_r.hi);
    check("abort_lo_kept", lo, exp_r.lo);
    repeat (40) @(negedge clk);

    // Reset in the middle of an op clears everything.
    start = 1'b1; alu_control = OP_MULT; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_dbz", div_by_zero, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    repeat (40) @(negedge clk);
    check("midrst_still_idle", busy, 0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
